instr_sequencer: RTL and testbench

//  Multicycle control sequencer for the MIPS datapath (register file, ALU, data memory).

---
 rtl/mips_pkg.sv | 30 +++
 rtl/instr_decode.sv | 34 +++
 rtl/instr_sequencer.sv | 117 +++++++++++
 tb/tb_instr_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, ALU op codes, sequencer states and decode record shared by the sequencer
package mips_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'd0;
    localparam logic [5:0] OP_LW       = 6'd35;
    localparam logic [5:0] OP_SW       = 6'd43;
    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        MEM,
        WB,
        DONE,
        ERR
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       is_load;
        logic       is_store;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic [1:0] alu_op;
    } decode_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational opcode decode into legality, access type and static datapath selects
module instr_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    output decode_t    dec_o
);

    always_comb begin
        dec_o = '0;
        case (opcode_i)
            OP_RTYPE: begin
                dec_o.legal   = 1'b1;
                dec_o.reg_dst = 1'b1;
                dec_o.alu_op  = ALUOP_FUNCT;
            end
            OP_LW: begin
                dec_o.legal      = 1'b1;
                dec_o.is_load    = 1'b1;
                dec_o.alu_src    = 1'b1;
                dec_o.mem_to_reg = 1'b1;
                dec_o.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                dec_o.legal    = 1'b1;
                dec_o.is_store = 1'b1;
                dec_o.alu_src  = 1'b1;
                dec_o.alu_op   = ALUOP_ADD;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multicycle control FSM driving MIPS datapath selects and strobes with counted timing
module instr_sequencer
    import mips_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int MEM_CYCLES  = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr_word,
    input  logic             hold,
    output logic             instr_ready,
    output logic [31:0]      instr_q,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int MAX_CYC = (EXEC_CYCLES > MEM_CYCLES) ? EXEC_CYCLES : MEM_CYCLES;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);
    localparam logic [CYC_W-1:0] EXEC_LAST = CYC_W'(EXEC_CYCLES - 1);
    localparam logic [CYC_W-1:0] MEM_LAST  = CYC_W'(MEM_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [31:0]      instr_word_q;
    logic [CNT_W-1:0] retired_q;
    decode_t          dec;
    logic             exec_last;
    logic             mem_last;
    logic             sel_en;

    instr_decode u_decode (
        .opcode_i (instr_word_q[31:26]),
        .dec_o    (dec)
    );

    assign exec_last   = (cyc_q == EXEC_LAST);
    assign mem_last    = (cyc_q == MEM_LAST);
    assign instr_q     = instr_word_q;
    assign retired_cnt = retired_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            instr_word_q <= '0;
            retired_q    <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            if (state_q == IDLE && instr_valid) begin
                instr_word_q <= instr_word;
            end
            if (state_q == DONE) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // hold freezes both the cycle counter and the state in EXEC and MEM only
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        case (state_q)
            IDLE:   if (instr_valid) state_d = DECODE;
            DECODE: begin
                cyc_d   = '0;
                state_d = dec.legal ? EXEC : ERR;
            end
            EXEC: if (!hold) begin
                if (exec_last) begin
                    cyc_d   = '0;
                    state_d = (dec.is_load || dec.is_store) ? MEM : WB;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            MEM: if (!hold) begin
                if (mem_last) begin
                    cyc_d   = '0;
                    state_d = dec.is_load ? WB : DONE;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            WB:      state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_en      = (state_q != IDLE) && (state_q != ERR);
        instr_ready = (state_q == IDLE);
        reg_dst     = sel_en & dec.reg_dst;
        alu_src     = sel_en & dec.alu_src;
        mem_to_reg  = sel_en & dec.mem_to_reg;
        alu_op      = sel_en ? dec.alu_op : ALUOP_ADD;
        reg_write   = (state_q == WB);
        mem_read    = (state_q == MEM) && dec.is_load;
        mem_write   = (state_q == MEM) && dec.is_store && mem_last && !hold;
        instr_done  = (state_q == DONE);
        illegal_op  = (state_q == ERR);
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with randomized instructions and hold patterns
module tb_instr_sequencer;

    localparam int EXEC_C = 1;
    localparam int MEM_C  = 2;
    localparam int CW     = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic [31:0]   instr_word;
    logic          hold;
    logic          instr_ready;
    logic [31:0]   instr_q;
    logic          reg_dst, alu_src, mem_to_reg;
    logic [1:0]    alu_op;
    logic          reg_write, mem_read, mem_write, instr_done, illegal_op;
    logic [CW-1:0] retired_cnt;

    instr_sequencer #(.EXEC_CYCLES(EXEC_C), .MEM_CYCLES(MEM_C), .CNT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_word  (instr_word),
        .hold        (hold),
        .instr_ready (instr_ready),
        .instr_q     (instr_q),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .mem_to_reg  (mem_to_reg),
        .alu_op      (alu_op),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .retired_cnt (retired_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] word;
        logic        illegal;
        int          lat;
        int          rw_n, mr_n, mw_n;
        int          rw_at, mr_at, mw_at;
        logic        reg_dst, alu_src, mem_to_reg;
        logic [1:0]  alu_op;
        int          cnt;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   model_cnt = 0;
    bit   hold_pat [64];
    exp_t sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Timeline model: walks cycle offsets from the accept edge against the hold pattern
    function automatic exp_t build_exp(input logic [31:0] w, input int cnt_before);
        exp_t e;
        int t, n, mstart;
        logic [5:0] op;
        op = w[31:26];
        e = '0;
        e.word = w; e.cnt = cnt_before;
        e.rw_at = -1; e.mr_at = -1; e.mw_at = -1;
        if (op == 6'd0 || op == 6'd35 || op == 6'd43) begin
            t = 2; n = 0;
            while (n < EXEC_C) begin if (!hold_pat[t]) n++; t++; end
            if (op != 6'd0) begin
                mstart = t; n = 0;
                while (n < MEM_C) begin if (!hold_pat[t]) n++; t++; end
                if (op == 6'd35) begin e.mr_n = t - mstart; e.mr_at = mstart; end
                else begin e.mw_n = 1; e.mw_at = t - 1; end
            end
            if (op != 6'd43) begin e.rw_n = 1; e.rw_at = t; t++; end
            e.lat = t;
            e.cnt = (cnt_before + 1) % (1 << CW);
            e.reg_dst    = (op == 6'd0);
            e.alu_src    = (op != 6'd0);
            e.mem_to_reg = (op == 6'd35);
            e.alu_op     = (op == 6'd0) ? 2'd2 : 2'd0;
        end else begin
            e.illegal = 1'b1;
            e.lat = 2;
        end
        return e;
    endfunction

    // Monitor
    exp_t e_m;
    bit   in_flight = 0, cnt_pending = 0;
    int   off, rw_n, mr_n, mw_n, rw_at, mr_at, mw_at;
    int   bad_idle = 0, bad_overlap = 0, bad_busy = 0;

    always @(negedge clock) begin
        if (!reset) begin
            in_flight = 0; cnt_pending = 0;
        end else begin
            if (cnt_pending) begin
                chk("retired_cnt", 32'(retired_cnt), e_m.cnt);
                chk("ready_after", 32'(instr_ready), 1);
                cnt_pending = 0;
            end
            if (in_flight) begin
                off++;
                if (instr_ready) bad_busy++;
                if (int'(reg_write) + int'(mem_read) + int'(mem_write) > 1) bad_overlap++;
                if (reg_write) begin rw_n++; if (rw_at < 0) rw_at = off; end
                if (mem_read)  begin mr_n++; if (mr_at < 0) mr_at = off; end
                if (mem_write) begin mw_n++; if (mw_at < 0) mw_at = off; end
                if (instr_done || illegal_op) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_retire", 1, 0);
                    end else begin
                        e_m = sb_q.pop_front();
                        chk("illegal_op", 32'(illegal_op), 32'(e_m.illegal));
                        chk("instr_done", 32'(instr_done), 32'(!e_m.illegal));
                        chk("latency", off, e_m.lat);
                        chk("instr_q", instr_q, e_m.word);
                        chk("reg_write_n", rw_n, e_m.rw_n);
                        chk("mem_read_n", mr_n, e_m.mr_n);
                        chk("mem_write_n", mw_n, e_m.mw_n);
                        chk("reg_write_at", rw_at, e_m.rw_at);
                        chk("mem_read_at", mr_at, e_m.mr_at);
                        chk("mem_write_at", mw_at, e_m.mw_at);
                        chk("selects", {reg_dst, alu_src, mem_to_reg, alu_op},
                            {e_m.reg_dst, e_m.alu_src, e_m.mem_to_reg, e_m.alu_op});
                    end
                    in_flight = 0; cnt_pending = 1;
                end
            end else begin
                if (reg_write | mem_read | mem_write | instr_done | illegal_op |
                    reg_dst | alu_src | mem_to_reg | (alu_op != 2'd0)) bad_idle++;
                if (instr_valid && instr_ready) begin
                    in_flight = 1; off = 0;
                    rw_n = 0; mr_n = 0; mw_n = 0; rw_at = -1; mr_at = -1; mw_at = -1;
                end
            end
        end
    end

    // hmode: 0 no hold, 1 random hold, 2 hold for three cycles at MEM entry
    task automatic run_instr(input logic [31:0] w, input int hmode, input bit keep_valid);
        exp_t e;
        logic [31:0] junk;
        for (int i = 0; i < 64; i++)
            hold_pat[i] = (hmode == 1 && i >= 2 && i < 40) ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (hmode == 2) begin hold_pat[3] = 1; hold_pat[4] = 1; hold_pat[5] = 1; end
        e = build_exp(w, model_cnt);
        model_cnt = e.cnt;
        sb_q.push_back(e);
        for (int i = 0; i < 50 && !instr_ready; i++) begin @(posedge clock); #1; end
        if (!instr_ready) begin
            chk("ready_wait", 0, 1);
            e = sb_q.pop_back();
            return;
        end
        instr_valid = 1'b1; instr_word = w;
        @(posedge clock); #1;
        junk = $urandom;
        instr_valid = keep_valid; instr_word = junk;
        for (int k = 1; k <= e.lat; k++) begin
            hold = hold_pat[k];
            @(posedge clock); #1;
        end
        hold = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [31:0] w, r;
    int          sel;
    logic [5:0]  op;

    initial begin
        reset = 1'b0; instr_valid = 1'b0; instr_word = '0; hold = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", 32'(instr_ready), 1);
        chk("rst_instr_q", instr_q, 0);
        chk("rst_retired", 32'(retired_cnt), 0);
        chk("rst_outputs", {reg_dst, alu_src, mem_to_reg, alu_op, reg_write, mem_read, mem_write,
                            instr_done, illegal_op}, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        run_instr(32'h012A4020, 0, 0);
        run_instr(32'h8D280004, 0, 0);
        run_instr(32'hAD280004, 2, 0);
        run_instr(32'h08000000, 0, 0);

        // reset while lw sits in MEM
        instr_valid = 1'b1; instr_word = 32'h8D280004;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        chk("pre_rst_mem_read", 32'(mem_read), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_outputs", {reg_dst, alu_src, mem_to_reg, alu_op, reg_write, mem_read, mem_write,
                                  instr_done, illegal_op}, 0);
        chk("async_rst_ready", 32'(instr_ready), 1);
        chk("async_rst_instr_q", instr_q, 0);
        chk("async_rst_retired", 32'(retired_cnt), 0);
        model_cnt = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        run_instr(32'h012A4020, 0, 0);

        for (int i = 0; i < 17; i++) begin
            r = $urandom;
            run_instr({6'd0, r[25:6], 6'h20}, 0, 1);
        end
        instr_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            sel = $urandom_range(0, 3);
            case (sel)
                0: op = 6'd0;
                1: op = 6'd35;
                2: op = 6'd43;
                default: begin
                    op = 6'($urandom_range(1, 63));
                    if (op == 6'd35 || op == 6'd43) op = 6'd2;
                end
            endcase
            w = {op, r[25:0]};
            run_instr(w, 1, i[0]);
        end
        instr_valid = 1'b0;

        repeat (4) @(posedge clock);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        chk("idle_quiet", bad_idle, 0);
        chk("strobe_overlap", bad_overlap, 0);
        chk("ready_while_busy", bad_busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
